// File: rtl/html_char_source.sv
// Prefetching byte feeder for html_parser: reads a page from a 1-cycle-latency ROM,
// collapses whitespace runs to one space and ends the page on NUL or after MAX_LEN bytes.
module html_char_source #(
    parameter int ADDR_W     = 12,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_LEN    = 4095,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    output logic [7:0]        char,
    output logic              char_valid,
    input  logic              next_char,
    output logic              has_finished,
    output logic              underrun
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_LEN);
    localparam logic [OCC_W:0]    DEPTH_L = (OCC_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_count;
    logic               r_inflight, r_last_space, r_finished, r_underrun;
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr, w_rd_ptr_nxt;
    logic [OCC_W-1:0]   r_occ, w_occ_nxt, w_occ_kept;
    logic [OCC_W:0]     w_level;
    logic [7:0]         r_char, w_head_nxt, w_push_data;
    logic               r_char_valid;
    logic               w_ret, w_is_space, w_term, w_push, w_pop, w_issue, w_start;

    // Return filter, issue decision and next FIFO head
    always_comb begin
        w_ret      = r_inflight && (r_state == S_FETCH);
        w_is_space = 1'b0;
        case (rom_data)
            8'h09, 8'h0A, 8'h0D, 8'h20: w_is_space = 1'b1;
            default:                    w_is_space = 1'b0;
        endcase
        w_term       = w_ret && (rom_data == 8'h00);
        w_push       = w_ret && !w_term && !(w_is_space && r_last_space);
        w_push_data  = w_is_space ? 8'h20 : rom_data;
        w_pop        = next_char && r_char_valid;
        w_level      = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
        // A terminator coming back stops fetching immediately so DRAIN has nothing to wait for
        w_issue      = (r_state == S_FETCH) && !w_term && (r_count < MAX_C) && (w_level < DEPTH_L);
        w_start      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
        w_occ_kept   = r_occ - {{(OCC_W-1){1'b0}}, w_pop};
        w_occ_nxt    = w_occ_kept + {{(OCC_W-1){1'b0}}, w_push};
        if (w_occ_nxt == '0) begin
            w_head_nxt = 8'h00;
        end else if (w_occ_kept == '0) begin
            w_head_nxt = w_push_data;
        end else begin
            w_head_nxt = r_fifo[w_rd_ptr_nxt];
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH; else w_state_nxt = S_IDLE;
            S_FETCH: if (w_term || (w_ret && (r_count == MAX_C))) w_state_nxt = S_DRAIN;
                     else w_state_nxt = S_FETCH;
            S_DRAIN: if ((r_occ == '0) && !r_inflight) w_state_nxt = S_DONE;
                     else w_state_nxt = S_DRAIN;
            S_DONE:  if (start) w_state_nxt = S_FETCH; else w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Fetch address, length count, filter memory and sticky status
    always_ff @(posedge clock) begin
        if (reset || w_start) begin
            r_addr       <= BASE_A;
            r_count      <= '0;
            r_inflight   <= 1'b0;
            r_last_space <= 1'b1;
            r_finished   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= r_count + CNT_W'(1);
            end
            if (w_push) r_last_space <= w_is_space;
            if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) r_finished <= 1'b1;
            if (next_char && !r_char_valid) r_underrun <= 1'b1;
        end
    end

    // Prefetch buffer storage
    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
    end

    // Prefetch buffer pointers and registered head
    always_ff @(posedge clock) begin
        if (reset || w_start) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_occ        <= '0;
            r_char       <= 8'h00;
            r_char_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_occ        <= w_occ_nxt;
            r_char       <= w_head_nxt;
            r_char_valid <= (w_occ_nxt != '0);
        end
    end

    assign rom_addr     = r_addr;
    assign rom_rd       = w_issue;
    assign char         = r_char;
    assign char_valid   = r_char_valid;
    assign has_finished = r_finished;
    assign underrun     = r_underrun;

    html_char_source_chk #(.OCC_W(OCC_W), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .occ   (r_occ)
    );
endmodule

// Checker: the issue rule must never let a return land in a full prefetch buffer.
module html_char_source_chk #(
    parameter int OCC_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clock,
    input logic             reset,
    input logic             push,
    input logic [OCC_W-1:0] occ
);
    // No push while full
    always_ff @(posedge clock) begin
        if (!reset) assert (!(push && (occ == OCC_W'(FIFO_DEPTH))));
    end
endmodule
